// File: rtl/axi_arbiter_pkg.sv
// Shared state encodings, grant identifiers and AXI protocol constants
// for the two-master (IFU/LSU) AXI arbiter.
package axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_IFU = 2'd1,
    ST_RD_LSU = 2'd2,
    ST_WR_LSU = 2'd3
  } arbState_e;

  typedef enum logic {
    GRANT_IFU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic grant_e otherGrant(input grant_e g);
    return (g == GRANT_IFU) ? GRANT_LSU : GRANT_IFU;
  endfunction

endpackage

// File: rtl/axi_arbiter_rr_pick.sv
// Two-input read selector: round-robin (or fixed LSU priority) with a
// registered record of the master that won the most recent read grant.
module axi_rr_pick
  import axi_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic   i_clock,
  input  logic   i_reset_n,
  input  logic   i_req_ifu,
  input  logic   i_req_lsu,
  input  logic   i_update,
  output grant_e o_grant
);

  grant_e lastGrant_q, lastGrant_d;

  always_comb begin
    o_grant = GRANT_IFU;
    if (i_req_ifu && i_req_lsu) begin
      o_grant = RR_EN ? otherGrant(lastGrant_q) : GRANT_LSU;
    end else if (i_req_lsu) begin
      o_grant = GRANT_LSU;
    end
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (i_update) begin
      lastGrant_d = o_grant;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lastGrant_q <= GRANT_IFU;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/axi_arbiter.sv
// Shares one AXI4 slave port between the IFU (read bursts) and the LSU
// (single-beat reads/writes); one transaction outstanding at a time.
module axi_arbiter
  import axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  // IFU read
  input  logic [ADDR_W-1:0]   i_ifu_araddr,
  input  logic                i_ifu_arvalid,
  input  logic [ID_W-1:0]     i_ifu_arid,
  input  logic [7:0]          i_ifu_arlen,
  input  logic [2:0]          i_ifu_arsize,
  input  logic [1:0]          i_ifu_arburst,
  output logic                o_ifu_arready,
  output logic [DATA_W-1:0]   o_ifu_rdata,
  output logic [1:0]          o_ifu_rresp,
  output logic                o_ifu_rvalid,
  output logic                o_ifu_rlast,
  output logic [ID_W-1:0]     o_ifu_rid,
  input  logic                i_ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0]   i_lsu_araddr,
  input  logic                i_lsu_arvalid,
  input  logic [ID_W-1:0]     i_lsu_arid,
  input  logic [7:0]          i_lsu_arlen,
  input  logic [2:0]          i_lsu_arsize,
  input  logic [1:0]          i_lsu_arburst,
  output logic                o_lsu_arready,
  output logic [DATA_W-1:0]   o_lsu_rdata,
  output logic [1:0]          o_lsu_rresp,
  output logic                o_lsu_rvalid,
  output logic                o_lsu_rlast,
  output logic [ID_W-1:0]     o_lsu_rid,
  input  logic                i_lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0]   i_lsu_awaddr,
  input  logic                i_lsu_awvalid,
  input  logic [ID_W-1:0]     i_lsu_awid,
  input  logic [7:0]          i_lsu_awlen,
  input  logic [2:0]          i_lsu_awsize,
  input  logic [1:0]          i_lsu_awburst,
  output logic                o_lsu_awready,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  input  logic                i_lsu_wvalid,
  input  logic                i_lsu_wlast,
  output logic                o_lsu_wready,
  output logic [1:0]          o_lsu_bresp,
  output logic                o_lsu_bvalid,
  output logic [ID_W-1:0]     o_lsu_bid,
  input  logic                i_lsu_bready,
  // Slave side
  output logic [ADDR_W-1:0]   o_axi_araddr,
  output logic                o_axi_arvalid,
  output logic [ID_W-1:0]     o_axi_arid,
  output logic [7:0]          o_axi_arlen,
  output logic [2:0]          o_axi_arsize,
  output logic [1:0]          o_axi_arburst,
  input  logic                i_axi_arready,
  input  logic [DATA_W-1:0]   i_axi_rdata,
  input  logic [1:0]          i_axi_rresp,
  input  logic                i_axi_rvalid,
  input  logic                i_axi_rlast,
  input  logic [ID_W-1:0]     i_axi_rid,
  output logic                o_axi_rready,
  output logic [ADDR_W-1:0]   o_axi_awaddr,
  output logic                o_axi_awvalid,
  output logic [ID_W-1:0]     o_axi_awid,
  output logic [7:0]          o_axi_awlen,
  output logic [2:0]          o_axi_awsize,
  output logic [1:0]          o_axi_awburst,
  input  logic                i_axi_awready,
  output logic [DATA_W-1:0]   o_axi_wdata,
  output logic [DATA_W/8-1:0] o_axi_wstrb,
  output logic                o_axi_wvalid,
  output logic                o_axi_wlast,
  input  logic                i_axi_wready,
  input  logic [1:0]          i_axi_bresp,
  input  logic                i_axi_bvalid,
  input  logic [ID_W-1:0]     i_axi_bid,
  output logic                o_axi_bready
);

  arbState_e state_q, state_d;
  logic      arSent_q, arSent_d;
  logic      awSent_q, awSent_d;
  logic      wSent_q, wSent_d;
  grant_e    pickGrant;
  logic      pickUpdate;
  logic      rdIsLsu;
  logic      arValidSel;
  logic      rReadySel;

  axi_rr_pick #(
    .RR_EN (RR_EN)
  ) uPick (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_req_ifu (i_ifu_arvalid),
    .i_req_lsu (i_lsu_arvalid),
    .i_update  (pickUpdate),
    .o_grant   (pickGrant)
  );

  assign rdIsLsu = (state_q == ST_RD_LSU);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      arSent_q <= 1'b0;
      awSent_q <= 1'b0;
      wSent_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      arSent_q <= arSent_d;
      awSent_q <= awSent_d;
      wSent_q  <= wSent_d;
    end
  end

  // Every output defaults to zero so IDLE and reset present a quiet bus;
  // each busy state only opens the channels owned by its master.
  always_comb begin
    state_d       = state_q;
    arSent_d      = arSent_q;
    awSent_d      = awSent_q;
    wSent_d       = wSent_q;
    pickUpdate    = 1'b0;
    arValidSel    = 1'b0;
    rReadySel     = 1'b0;

    o_ifu_arready = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = '0;
    o_ifu_rvalid  = 1'b0;
    o_ifu_rlast   = 1'b0;
    o_ifu_rid     = '0;
    o_lsu_arready = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = '0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_rlast   = 1'b0;
    o_lsu_rid     = '0;
    o_lsu_awready = 1'b0;
    o_lsu_wready  = 1'b0;
    o_lsu_bresp   = '0;
    o_lsu_bvalid  = 1'b0;
    o_lsu_bid     = '0;
    o_axi_araddr  = '0;
    o_axi_arvalid = 1'b0;
    o_axi_arid    = '0;
    o_axi_arlen   = '0;
    o_axi_arsize  = '0;
    o_axi_arburst = '0;
    o_axi_rready  = 1'b0;
    o_axi_awaddr  = '0;
    o_axi_awvalid = 1'b0;
    o_axi_awid    = '0;
    o_axi_awlen   = '0;
    o_axi_awsize  = '0;
    o_axi_awburst = '0;
    o_axi_wdata   = '0;
    o_axi_wstrb   = '0;
    o_axi_wvalid  = 1'b0;
    o_axi_wlast   = 1'b0;
    o_axi_bready  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_lsu_awvalid) begin
          state_d = ST_WR_LSU;
        end else if (i_ifu_arvalid || i_lsu_arvalid) begin
          pickUpdate = 1'b1;
          state_d    = (pickGrant == GRANT_LSU) ? ST_RD_LSU : ST_RD_IFU;
        end
      end

      ST_RD_IFU, ST_RD_LSU: begin
        arValidSel    = rdIsLsu ? i_lsu_arvalid : i_ifu_arvalid;
        rReadySel     = rdIsLsu ? i_lsu_rready  : i_ifu_rready;
        o_axi_araddr  = rdIsLsu ? i_lsu_araddr  : i_ifu_araddr;
        o_axi_arid    = rdIsLsu ? i_lsu_arid    : i_ifu_arid;
        o_axi_arlen   = rdIsLsu ? i_lsu_arlen   : i_ifu_arlen;
        o_axi_arsize  = rdIsLsu ? i_lsu_arsize  : i_ifu_arsize;
        o_axi_arburst = rdIsLsu ? i_lsu_arburst : i_ifu_arburst;
        o_axi_arvalid = arValidSel & ~arSent_q;
        o_axi_rready  = rReadySel;
        if (rdIsLsu) begin
          o_lsu_arready = i_axi_arready & ~arSent_q;
          o_lsu_rdata   = i_axi_rdata;
          o_lsu_rresp   = i_axi_rresp;
          o_lsu_rvalid  = i_axi_rvalid;
          o_lsu_rlast   = i_axi_rlast;
          o_lsu_rid     = i_axi_rid;
        end else begin
          o_ifu_arready = i_axi_arready & ~arSent_q;
          o_ifu_rdata   = i_axi_rdata;
          o_ifu_rresp   = i_axi_rresp;
          o_ifu_rvalid  = i_axi_rvalid;
          o_ifu_rlast   = i_axi_rlast;
          o_ifu_rid     = i_axi_rid;
        end
        if (arValidSel && i_axi_arready && !arSent_q) begin
          arSent_d = 1'b1;
        end
        if (i_axi_rvalid && rReadySel && i_axi_rlast) begin
          arSent_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      // AW and W progress independently; each is masked once it has landed.
      ST_WR_LSU: begin
        o_axi_awaddr  = i_lsu_awaddr;
        o_axi_awid    = i_lsu_awid;
        o_axi_awlen   = i_lsu_awlen;
        o_axi_awsize  = i_lsu_awsize;
        o_axi_awburst = i_lsu_awburst;
        o_axi_awvalid = i_lsu_awvalid & ~awSent_q;
        o_lsu_awready = i_axi_awready & ~awSent_q;
        o_axi_wdata   = i_lsu_wdata;
        o_axi_wstrb   = i_lsu_wstrb;
        o_axi_wlast   = i_lsu_wlast;
        o_axi_wvalid  = i_lsu_wvalid & ~wSent_q;
        o_lsu_wready  = i_axi_wready & ~wSent_q;
        o_lsu_bresp   = i_axi_bresp;
        o_lsu_bid     = i_axi_bid;
        o_lsu_bvalid  = i_axi_bvalid;
        o_axi_bready  = i_lsu_bready;
        if (i_lsu_awvalid && i_axi_awready && !awSent_q) begin
          awSent_d = 1'b1;
        end
        if (i_lsu_wvalid && i_axi_wready && i_lsu_wlast && !wSent_q) begin
          wSent_d = 1'b1;
        end
        if (i_axi_bvalid && i_lsu_bready) begin
          awSent_d = 1'b0;
          wSent_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: a small behavioural AXI slave plus IFU/LSU
// master tasks, with hand-computed expectations checked through checkOutput.
module tb_axi_arbiter;
  import axi_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int WSTALL = 3;

  logic clock = 1'b0;
  logic i_reset_n;

  logic [ADDR_W-1:0] i_ifu_araddr, i_lsu_araddr, i_lsu_awaddr;
  logic              i_ifu_arvalid, i_lsu_arvalid, i_lsu_awvalid;
  logic [ID_W-1:0]   i_ifu_arid, i_lsu_arid, i_lsu_awid;
  logic [7:0]        i_ifu_arlen, i_lsu_arlen, i_lsu_awlen;
  logic [2:0]        i_ifu_arsize, i_lsu_arsize, i_lsu_awsize;
  logic [1:0]        i_ifu_arburst, i_lsu_arburst, i_lsu_awburst;
  logic              i_ifu_rready, i_lsu_rready, i_lsu_bready;
  logic [DATA_W-1:0] i_lsu_wdata;
  logic [3:0]        i_lsu_wstrb;
  logic              i_lsu_wvalid, i_lsu_wlast;

  logic              o_ifu_arready, o_lsu_arready, o_lsu_awready, o_lsu_wready;
  logic [DATA_W-1:0] o_ifu_rdata, o_lsu_rdata;
  logic [1:0]        o_ifu_rresp, o_lsu_rresp, o_lsu_bresp;
  logic              o_ifu_rvalid, o_lsu_rvalid, o_ifu_rlast, o_lsu_rlast, o_lsu_bvalid;
  logic [ID_W-1:0]   o_ifu_rid, o_lsu_rid, o_lsu_bid;

  logic [ADDR_W-1:0] o_axi_araddr, o_axi_awaddr;
  logic              o_axi_arvalid, o_axi_awvalid, o_axi_wvalid, o_axi_wlast;
  logic              o_axi_rready, o_axi_bready;
  logic [ID_W-1:0]   o_axi_arid, o_axi_awid;
  logic [7:0]        o_axi_arlen, o_axi_awlen;
  logic [2:0]        o_axi_arsize, o_axi_awsize;
  logic [1:0]        o_axi_arburst, o_axi_awburst;
  logic [DATA_W-1:0] o_axi_wdata;
  logic [3:0]        o_axi_wstrb;

  logic              i_axi_arready, i_axi_awready, i_axi_wready;
  logic [DATA_W-1:0] i_axi_rdata;
  logic [1:0]        i_axi_rresp, i_axi_bresp;
  logic              i_axi_rvalid, i_axi_rlast, i_axi_bvalid;
  logic [ID_W-1:0]   i_axi_rid, i_axi_bid;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleCnt      = 0;
  int grantSeq      = 0;

  // Slave model state and knobs
  logic [1:0]        slvRresp = RESP_OKAY;
  bit                slvRdActive, slvAwDone, slvWDone;
  int                slvRdBeat, slvRdLen, slvWStallCnt, slvAwHsCount;
  logic [ADDR_W-1:0] slvRdAddr, slvCapAwAddr;
  logic [ID_W-1:0]   slvRdId, slvBId;
  logic [DATA_W-1:0] slvCapWdata;
  logic [3:0]        slvCapWstrb;

  axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RR_EN(1'b1)) dut (
    .i_clock(clock), .i_reset_n(i_reset_n),
    .i_ifu_araddr(i_ifu_araddr), .i_ifu_arvalid(i_ifu_arvalid), .i_ifu_arid(i_ifu_arid),
    .i_ifu_arlen(i_ifu_arlen), .i_ifu_arsize(i_ifu_arsize), .i_ifu_arburst(i_ifu_arburst),
    .o_ifu_arready(o_ifu_arready), .o_ifu_rdata(o_ifu_rdata), .o_ifu_rresp(o_ifu_rresp),
    .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_rlast(o_ifu_rlast), .o_ifu_rid(o_ifu_rid),
    .i_ifu_rready(i_ifu_rready),
    .i_lsu_araddr(i_lsu_araddr), .i_lsu_arvalid(i_lsu_arvalid), .i_lsu_arid(i_lsu_arid),
    .i_lsu_arlen(i_lsu_arlen), .i_lsu_arsize(i_lsu_arsize), .i_lsu_arburst(i_lsu_arburst),
    .o_lsu_arready(o_lsu_arready), .o_lsu_rdata(o_lsu_rdata), .o_lsu_rresp(o_lsu_rresp),
    .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_rlast(o_lsu_rlast), .o_lsu_rid(o_lsu_rid),
    .i_lsu_rready(i_lsu_rready),
    .i_lsu_awaddr(i_lsu_awaddr), .i_lsu_awvalid(i_lsu_awvalid), .i_lsu_awid(i_lsu_awid),
    .i_lsu_awlen(i_lsu_awlen), .i_lsu_awsize(i_lsu_awsize), .i_lsu_awburst(i_lsu_awburst),
    .o_lsu_awready(o_lsu_awready), .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb),
    .i_lsu_wvalid(i_lsu_wvalid), .i_lsu_wlast(i_lsu_wlast), .o_lsu_wready(o_lsu_wready),
    .o_lsu_bresp(o_lsu_bresp), .o_lsu_bvalid(o_lsu_bvalid), .o_lsu_bid(o_lsu_bid),
    .i_lsu_bready(i_lsu_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .o_axi_arid(o_axi_arid),
    .o_axi_arlen(o_axi_arlen), .o_axi_arsize(o_axi_arsize), .o_axi_arburst(o_axi_arburst),
    .i_axi_arready(i_axi_arready), .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
    .i_axi_rvalid(i_axi_rvalid), .i_axi_rlast(i_axi_rlast), .i_axi_rid(i_axi_rid),
    .o_axi_rready(o_axi_rready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .o_axi_awid(o_axi_awid),
    .o_axi_awlen(o_axi_awlen), .o_axi_awsize(o_axi_awsize), .o_axi_awburst(o_axi_awburst),
    .i_axi_awready(i_axi_awready), .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .o_axi_wvalid(o_axi_wvalid), .o_axi_wlast(o_axi_wlast), .i_axi_wready(i_axi_wready),
    .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .i_axi_bid(i_axi_bid),
    .o_axi_bready(o_axi_bready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  function automatic logic [11:0] busValids();
    return {o_ifu_rvalid, o_lsu_rvalid, o_lsu_bvalid, o_axi_arvalid, o_axi_awvalid,
            o_axi_wvalid, o_axi_rready, o_axi_bready, o_ifu_arready, o_lsu_arready,
            o_lsu_awready, o_lsu_wready};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Slave: samples handshakes at negedge, drives its outputs just after posedge.
  // Read data is address + 4*beat; wready is held low WSTALL cycles after AW.
  initial begin
    slvRdActive = 0; slvAwDone = 0; slvWDone = 0; slvAwHsCount = 0;
    slvRdBeat = 0; slvRdLen = 0; slvWStallCnt = 0;
    slvRdAddr = '0; slvRdId = '0; slvBId = '0;
    slvCapAwAddr = '0; slvCapWdata = '0; slvCapWstrb = '0;
    i_axi_arready = 1'b1; i_axi_awready = 1'b1; i_axi_wready = 1'b0;
    i_axi_rvalid = 1'b0; i_axi_rdata = '0; i_axi_rresp = '0; i_axi_rlast = 1'b0;
    i_axi_rid = '0; i_axi_bvalid = 1'b0; i_axi_bresp = '0; i_axi_bid = '0;
    forever begin
      @(negedge clock);
      if (!i_reset_n) begin
        slvRdActive = 0; slvAwDone = 0; slvWDone = 0; slvWStallCnt = 0;
      end else begin
        if (i_axi_rvalid && o_axi_rready) begin
          if (slvRdBeat == slvRdLen) slvRdActive = 0;
          else slvRdBeat++;
        end
        if (o_axi_arvalid && i_axi_arready) begin
          slvRdActive = 1; slvRdBeat = 0; slvRdLen = int'(o_axi_arlen);
          slvRdAddr = o_axi_araddr; slvRdId = o_axi_arid;
        end
        if (o_axi_awvalid && i_axi_awready) begin
          slvAwDone = 1; slvWStallCnt = WSTALL; slvBId = o_axi_awid;
          slvCapAwAddr = o_axi_awaddr; slvAwHsCount++;
        end else if (slvAwDone && slvWStallCnt > 0) begin
          slvWStallCnt--;
        end
        if (o_axi_wvalid && i_axi_wready && o_axi_wlast) begin
          slvWDone = 1; slvCapWdata = o_axi_wdata; slvCapWstrb = o_axi_wstrb;
        end
        if (i_axi_bvalid && o_axi_bready) begin
          slvAwDone = 0; slvWDone = 0;
        end
      end
      @(posedge clock); #1;
      i_axi_rvalid = slvRdActive;
      i_axi_rdata  = slvRdAddr + 32'(4 * slvRdBeat);
      i_axi_rlast  = slvRdActive && (slvRdBeat == slvRdLen);
      i_axi_rid    = slvRdId;
      i_axi_rresp  = slvRresp;
      i_axi_wready = slvAwDone && !slvWDone && (slvWStallCnt == 0);
      i_axi_bvalid = slvAwDone && slvWDone;
      i_axi_bid    = slvBId;
      i_axi_bresp  = RESP_OKAY;
    end
  end

  task automatic applyStimulusRead(input bit isLsu, input logic [31:0] addr,
                                   input logic [7:0] len, input logic [3:0] id,
                                   input logic [1:0] expResp, output int order,
                                   output int arCycle);
    string pfx = isLsu ? "lsu" : "ifu";
    bit hs = 0;
    bit gotLast = 0;
    bit leak = 0;
    int beats = 0;
    order = -1;
    arCycle = -1;
    @(posedge clock); #1;
    if (isLsu) begin
      i_lsu_araddr = addr; i_lsu_arlen = len; i_lsu_arid = id; i_lsu_arsize = 3'd2;
      i_lsu_arburst = BURST_INCR; i_lsu_arvalid = 1'b1; i_lsu_rready = 1'b1;
    end else begin
      i_ifu_araddr = addr; i_ifu_arlen = len; i_ifu_arid = id; i_ifu_arsize = 3'd2;
      i_ifu_arburst = BURST_INCR; i_ifu_arvalid = 1'b1; i_ifu_rready = 1'b1;
    end
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clock);
      if (isLsu ? o_lsu_arready : o_ifu_arready) begin
        hs = 1; order = grantSeq; grantSeq++; arCycle = cycleCnt;
      end
    end
    checkOutput({pfx, "ArGranted"}, 64'(hs), 64'd1);
    @(posedge clock); #1;
    if (isLsu) i_lsu_arvalid = 1'b0;
    else i_ifu_arvalid = 1'b0;
    for (int c = 0; c < 200 && !gotLast && hs; c++) begin
      @(negedge clock);
      if (isLsu ? o_ifu_rvalid : o_lsu_rvalid) leak = 1;
      if (isLsu ? o_lsu_rvalid : o_ifu_rvalid) begin
        checkOutput({pfx, "Rdata"}, isLsu ? o_lsu_rdata : o_ifu_rdata,
                    64'(addr + 32'(4 * beats)));
        checkOutput({pfx, "Rresp"}, isLsu ? o_lsu_rresp : o_ifu_rresp, 64'(expResp));
        checkOutput({pfx, "Rid"}, isLsu ? o_lsu_rid : o_ifu_rid, 64'(id));
        checkOutput({pfx, "Rlast"}, isLsu ? o_lsu_rlast : o_ifu_rlast,
                    64'(beats == int'(len)));
        if (isLsu ? o_lsu_rlast : o_ifu_rlast) gotLast = 1;
        beats++;
      end
    end
    checkOutput({pfx, "Beats"}, 64'(beats), 64'(int'(len) + 1));
    checkOutput({pfx, "OtherRvalid"}, 64'(leak), 64'd0);
    @(negedge clock);
    checkOutput({pfx, "IdleAfter"}, 64'(dut.state_q), 64'(ST_IDLE));
    if (isLsu) i_lsu_rready = 1'b0;
    else i_ifu_rready = 1'b0;
  endtask

  task automatic applyStimulusWrite(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, input logic [3:0] id,
                                    output int bCycle);
    bit awSeen = 0;
    bit wSeen = 0;
    bit bSeen = 0;
    bit awLeak = 0;
    int stall = 0;
    int awBefore = slvAwHsCount;
    bCycle = -1;
    @(posedge clock); #1;
    i_lsu_awaddr = addr; i_lsu_awid = id; i_lsu_awlen = 8'd0; i_lsu_awsize = 3'd2;
    i_lsu_awburst = BURST_INCR; i_lsu_awvalid = 1'b1;
    i_lsu_wdata = data; i_lsu_wstrb = strb; i_lsu_wlast = 1'b1; i_lsu_wvalid = 1'b1;
    i_lsu_bready = 1'b1;
    for (int c = 0; c < 200 && !bSeen; c++) begin
      @(negedge clock);
      if (awSeen && !wSeen && o_axi_awvalid) awLeak = 1;
      if (awSeen && !wSeen && o_axi_wvalid && !i_axi_wready) stall++;
      if (o_lsu_bvalid) begin
        bSeen = 1; bCycle = cycleCnt;
        checkOutput("wrBresp", o_lsu_bresp, 64'(RESP_OKAY));
        checkOutput("wrBid", o_lsu_bid, 64'(id));
      end
      if (!awSeen && o_lsu_awready) awSeen = 1;
      if (!wSeen && i_lsu_wvalid && o_lsu_wready) begin
        wSeen = 1;
        @(posedge clock); #1;
        i_lsu_wvalid = 1'b0;
      end
    end
    checkOutput("wrBSeen", 64'(bSeen), 64'd1);
    checkOutput("wrWStallHeld", 64'(stall), 64'(WSTALL));
    checkOutput("wrAwDropped", 64'(awLeak), 64'd0);
    checkOutput("wrAwCount", 64'(slvAwHsCount - awBefore), 64'd1);
    checkOutput("wrAwAddr", slvCapAwAddr, 64'(addr));
    checkOutput("wrWdata", slvCapWdata, 64'(data));
    checkOutput("wrWstrb", slvCapWstrb, 64'(strb));
    @(posedge clock); #1;
    i_lsu_awvalid = 1'b0; i_lsu_bready = 1'b0;
    @(negedge clock);
    checkOutput("wrIdleAfter", 64'(dut.state_q), 64'(ST_IDLE));
  endtask

  initial begin : mainSeq
    int ifuOrd, lsuOrd, ifuCyc, lsuCyc, bCyc, beats;
    bit hs;
    i_reset_n = 1'b0;
    i_ifu_araddr = '0; i_ifu_arvalid = 0; i_ifu_arid = '0; i_ifu_arlen = '0;
    i_ifu_arsize = '0; i_ifu_arburst = '0; i_ifu_rready = 0;
    i_lsu_araddr = '0; i_lsu_arvalid = 0; i_lsu_arid = '0; i_lsu_arlen = '0;
    i_lsu_arsize = '0; i_lsu_arburst = '0; i_lsu_rready = 0;
    i_lsu_awaddr = '0; i_lsu_awvalid = 0; i_lsu_awid = '0; i_lsu_awlen = '0;
    i_lsu_awsize = '0; i_lsu_awburst = '0; i_lsu_wdata = '0; i_lsu_wstrb = '0;
    i_lsu_wvalid = 0; i_lsu_wlast = 0; i_lsu_bready = 0;

    repeat (3) @(negedge clock);
    checkOutput("rstState", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("rstOutputs", 64'(busValids()), 64'd0);
    i_reset_n = 1'b1;
    @(negedge clock);
    checkOutput("idleOutputs", 64'(busValids()), 64'd0);

    $display("[TB] IFU burst alone");
    applyStimulusRead(1'b0, 32'h8000_0000, 8'd3, 4'h1, RESP_OKAY, ifuOrd, ifuCyc);

    $display("[TB] LSU store with W stall");
    applyStimulusWrite(32'h8000_0104, 32'hDEAD_BEEF, 4'b1111, 4'h2, bCyc);

    $display("[TB] simultaneous reads, round-robin");
    for (int p = 0; p < 2; p++) begin
      fork
        applyStimulusRead(1'b0, 32'h8000_1000, 8'd1, 4'h3, RESP_OKAY, ifuOrd, ifuCyc);
        applyStimulusRead(1'b1, 32'h8000_2000, 8'd0, 4'h4, RESP_OKAY, lsuOrd, lsuCyc);
      join
      checkOutput("rrLsuFirst", 64'(lsuOrd < ifuOrd), 64'd1);
      checkOutput("rrIfuNext", 64'(ifuOrd - lsuOrd), 64'd1);
    end

    $display("[TB] write versus IFU read");
    fork
      applyStimulusWrite(32'h8000_0108, 32'h1234_5678, 4'b0011, 4'h7, bCyc);
      applyStimulusRead(1'b0, 32'h8000_0400, 8'd1, 4'h8, RESP_OKAY, ifuOrd, ifuCyc);
    join
    checkOutput("wrThenRdGap", 64'(ifuCyc - bCyc), 64'd2);

    $display("[TB] reset during burst");
    @(posedge clock); #1;
    i_ifu_araddr = 32'h8000_0040; i_ifu_arlen = 8'd3; i_ifu_arid = 4'h9;
    i_ifu_arsize = 3'd2; i_ifu_arburst = BURST_INCR; i_ifu_arvalid = 1'b1; i_ifu_rready = 1'b1;
    hs = 0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clock);
      if (o_ifu_arready) hs = 1;
    end
    checkOutput("rstArGranted", 64'(hs), 64'd1);
    @(posedge clock); #1;
    i_ifu_arvalid = 1'b0;
    hs = 0;
    beats = 0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clock);
      if (o_ifu_rvalid) begin
        if (beats == 1) hs = 1;
        else beats++;
      end
    end
    checkOutput("rstBeat2Seen", 64'(hs), 64'd1);
    checkOutput("rstBeat2Data", o_ifu_rdata, 64'h8000_0044);
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("rstAsyncOutputs", 64'(busValids()), 64'd0);
    checkOutput("rstAsyncState", 64'(dut.state_q), 64'(ST_IDLE));
    i_ifu_rready = 1'b0;
    repeat (2) @(negedge clock);
    i_reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rstReleaseState", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("rstReleaseOutputs", 64'(busValids()), 64'd0);
    applyStimulusRead(1'b1, 32'h8000_0200, 8'd0, 4'h5, RESP_OKAY, lsuOrd, lsuCyc);

    $display("[TB] slave error on LSU read");
    slvRresp = RESP_SLVERR;
    applyStimulusRead(1'b1, 32'h8000_0300, 8'd0, 4'h6, RESP_SLVERR, lsuOrd, lsuCyc);
    slvRresp = RESP_OKAY;
    applyStimulusRead(1'b0, 32'h8000_0500, 8'd0, 4'hA, RESP_OKAY, ifuOrd, ifuCyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Two-master, one-slave AXI4 arbiter that shares the single memory/peripheral AXI port between the instruction fetch unit (IFU, read-only, may burst) and the load/store unit (LSU, single-beat reads and writes).
- Sits between the IFU/LSU master ports and the top-level AXI master of the core.
- Exactly one transaction is outstanding at a time; the bus is owned from grant until the final R beat or B response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ID_W, 4, AXI id width.
- RR_EN, 1, 1 = round-robin on IFU/LSU read contention; 0 = fixed LSU priority.

Ports:
- i_clock  input  1  core clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_ifu_araddr / i_ifu_arvalid / i_ifu_arid / i_ifu_arlen / i_ifu_arsize / i_ifu_arburst  input  ADDR_W/1/ID_W/8/3/2  IFU read address.
- o_ifu_arready  output  1  IFU AR accept.
- o_ifu_rdata / o_ifu_rresp / o_ifu_rvalid / o_ifu_rlast / o_ifu_rid  output  DATA_W/2/1/1/ID_W  IFU read data.
- i_ifu_rready  input  1  IFU R accept.
- i_lsu_araddr / i_lsu_arvalid / i_lsu_arid / i_lsu_arlen / i_lsu_arsize / i_lsu_arburst  input  as IFU  LSU read address.
- o_lsu_arready  output  1  LSU AR accept.
- o_lsu_rdata / o_lsu_rresp / o_lsu_rvalid / o_lsu_rlast / o_lsu_rid  output  as IFU  LSU read data.
- i_lsu_rready  input  1  LSU R accept.
- i_lsu_awaddr / i_lsu_awvalid / i_lsu_awid / i_lsu_awlen / i_lsu_awsize / i_lsu_awburst  input  ADDR_W/1/ID_W/8/3/2  LSU write address.
- o_lsu_awready  output  1  LSU AW accept.
- i_lsu_wdata / i_lsu_wstrb / i_lsu_wvalid / i_lsu_wlast  input  DATA_W/4/1/1  LSU write data.
- o_lsu_wready  output  1  LSU W accept.
- o_lsu_bresp / o_lsu_bvalid / o_lsu_bid  output  2/1/ID_W  LSU write response.
- i_lsu_bready  input  1  LSU B accept.
- o_axi_* (ar, aw, w channels, plus rready and bready)  output  matching widths  slave-side request signals.
- i_axi_* (arready, awready, wready, R and B channels)  input  matching widths  slave-side response signals.

Behaviour:
- FSM states: IDLE, RD_IFU, RD_LSU, WR_LSU. Reset (async, i_reset_n low): state=IDLE, last_grant=IFU, ar_sent=aw_sent=w_sent=0.
- All outputs read 0 while in reset and in IDLE; slave-side valids/readies are combinational from state and the sent flags.
- IDLE decision (registered, takes effect next cycle):
  - LSU write (i_lsu_awvalid) has highest priority, goes to WR_LSU.
  - Otherwise, if only one of IFU/LSU arvalid is high, go to that master's read state.
  - If both are high: with RR_EN=1, grant the master not equal to last_grant; with RR_EN=0, grant LSU.
  - last_grant updates on every read grant.
- RD_x:
  - o_axi_ar* = master x fields; o_axi_arvalid = x_arvalid & !ar_sent.
  - x_arready = i_axi_arready & !ar_sent. ar_sent is set on the AR handshake.
  - R channel is routed to x only: o_axi_rready = x_rready. The other master sees rvalid=0 and arready=0.
  - Leave to IDLE on i_axi_rvalid & o_axi_rready & i_axi_rlast; clear ar_sent.
- WR_LSU:
  - AW and W are forwarded independently: o_axi_awvalid = awvalid & !aw_sent, and o_axi_wvalid = wvalid & !w_sent.
  - aw_sent sets on the AW handshake. w_sent sets on a W handshake with wlast.
  - If AW and W complete in the same cycle, both flags set.
  - B is routed to the LSU; leave to IDLE on bvalid & bready; clear both flags.
- Latency: request in IDLE means the slave sees valid one cycle later. At least one IDLE cycle separates transactions.
- Responses (including SLVERR/DECERR) pass through unchanged. IDs are passed through.
- A master dropping valid before its handshake is illegal; behaviour is undefined. No assertion is required.
- Reset asserted mid-burst returns to IDLE immediately. Any in-flight slave beat is dropped (the slave shares the same reset).

Decomposition:
- Shared package/header: FSM state encodings, and AXI burst/resp constants (BURST_INCR, RESP_OKAY, and so on).
- Optional sub-module axi_rr_pick: 2-input round-robin selector with a last_grant register. Everything else lives in a single module.

Test Plan:
- IFU alone: araddr=0x8000_0000, arlen=3 INCR.
  - Required: exactly 4 R beats reach the IFU, rlast on beat 4, then state IDLE.
  - Required: the LSU sees rvalid=0 throughout.
- LSU sw: AW and W (addr 0x8000_0104, wstrb=4'b1111) presented together.
  - Slave stalls wready 3 cycles after accepting AW.
  - Required: awvalid drops after the AW handshake, wvalid is held, bvalid reaches the LSU, then IDLE.
- Simultaneous IFU and LSU arvalid, RR_EN=1, last_grant=IFU.
  - Required: LSU granted first, IFU next; sequence repeated twice alternates grants.
- Simultaneous LSU awvalid and IFU arvalid.
  - Required: write completes first; the IFU read is granted the cycle after returning to IDLE.
- i_reset_n pulsed low during beat 2 of an arlen=3 burst.
  - Required: all o_* valids go to 0 asynchronously; state is IDLE after release; a new request is granted normally.
- Slave returns rresp=2'b10 on an LSU read.
  - Required: o_lsu_rresp=2'b10 and the transaction completes normally.
